// File: rtl/fpu_pkg.sv
// Shared bfloat16 types and constants for the FP issue path and its compute unit.
package fpu_pkg;
    localparam int BF16_EXP_W  = 8;
    localparam int BF16_FRAC_W = 7;

    localparam logic [15:0] BF16_POS_ZERO = 16'h0000;
    localparam logic [15:0] BF16_NEG_ZERO = 16'h8000;

    typedef struct packed {
        logic                   sign;
        logic [BF16_EXP_W-1:0]  exp;
        logic [BF16_FRAC_W-1:0] frac;
    } bf16_t;
endpackage

// File: rtl/op_intf.sv
// Unpacked operand/result bundle between the issue stage and a combinational FP unit.
interface op_intf #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 7
);
    logic                  op1_sign;
    logic [EXP_WIDTH-1:0]  op1_exp;
    logic [FRAC_WIDTH-1:0] op1_frac;
    logic                  op2_sign;
    logic [EXP_WIDTH-1:0]  op2_exp;
    logic [FRAC_WIDTH-1:0] op2_frac;
    logic                  op3_sign;
    logic [EXP_WIDTH-1:0]  op3_exp;
    logic [FRAC_WIDTH-1:0] op3_frac;

    modport comp_side (
        input  op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
        output op3_sign, op3_exp, op3_frac
    );

    modport drive_side (
        output op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
        input  op3_sign, op3_exp, op3_frac
    );
endinterface

// File: rtl/fp_add.sv
// Combinational FP adder on op_intf; assumes hidden 1 on both operands, truncates, no rounding.
module fp_add
    import fpu_pkg::*;
#(
    parameter int EXP_WIDTH  = BF16_EXP_W,
    parameter int FRAC_WIDTH = BF16_FRAC_W
) (
    op_intf.comp_side op_if
);
    localparam int MW = FRAC_WIDTH + 1;

    logic                 op1_big;
    logic                 sb;
    logic [EXP_WIDTH-1:0] eb;
    logic [EXP_WIDTH-1:0] es;
    logic [MW-1:0]        mb;
    logic [MW-1:0]        ms;
    logic [MW-1:0]        shifted;
    logic [MW:0]          sum;
    logic [MW-1:0]        dif;
    logic [MW-1:0]        norm;
    logic                 found;
    int                   lz;

    always_comb begin
        op1_big = (op_if.op1_exp > op_if.op2_exp) ||
                  ((op_if.op1_exp == op_if.op2_exp) && (op_if.op1_frac >= op_if.op2_frac));
        sb      = op1_big ? op_if.op1_sign : op_if.op2_sign;
        eb      = op1_big ? op_if.op1_exp : op_if.op2_exp;
        es      = op1_big ? op_if.op2_exp : op_if.op1_exp;
        mb      = op1_big ? {1'b1, op_if.op1_frac} : {1'b1, op_if.op2_frac};
        ms      = op1_big ? {1'b1, op_if.op2_frac} : {1'b1, op_if.op1_frac};
        shifted = ms >> (eb - es);
        sum     = {1'b0, mb} + {1'b0, shifted};
        dif     = mb - shifted;

        lz    = 0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found && dif[i]) begin
                lz    = MW - 1 - i;
                found = 1'b1;
            end
        end
        norm = dif << lz;

        op_if.op3_sign = sb;
        op_if.op3_exp  = eb;
        op_if.op3_frac = '0;
        if (op_if.op1_sign == op_if.op2_sign) begin
            if (sum[MW]) begin
                op_if.op3_exp  = eb + EXP_WIDTH'(1);
                op_if.op3_frac = sum[MW-1:1];
            end else begin
                op_if.op3_frac = sum[FRAC_WIDTH-1:0];
            end
        end else if (found && (eb > EXP_WIDTH'(lz))) begin
            op_if.op3_exp  = eb - EXP_WIDTH'(lz);
            op_if.op3_frac = norm[FRAC_WIDTH-1:0];
        end else begin
            // Exact cancellation or underflow collapses to +0.
            op_if.op3_sign = 1'b0;
            op_if.op3_exp  = '0;
        end
    end
endmodule

// File: rtl/fp_zero_bypass.sv
// Picks the final result: zero operands bypass the compute unit, which assumes a hidden 1.
module fp_zero_bypass
    import fpu_pkg::*;
#(
    parameter  int EXP_WIDTH  = BF16_EXP_W,
    parameter  int FRAC_WIDTH = BF16_FRAC_W,
    localparam int W          = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic [W-1:0]          op1,
    input  logic [W-1:0]          op2,
    input  logic                  op3_sign,
    input  logic [EXP_WIDTH-1:0]  op3_exp,
    input  logic [FRAC_WIDTH-1:0] op3_frac,
    output logic [W-1:0]          result
);
    logic op1_zero;
    logic op2_zero;

    // Exponent 0 means zero; subnormal fractions are flushed.
    assign op1_zero = (op1[W-2 -: EXP_WIDTH] == '0);
    assign op2_zero = (op2[W-2 -: EXP_WIDTH] == '0);

    always_comb begin
        result = {op3_sign, op3_exp, op3_frac};
        case ({op1_zero, op2_zero})
            2'b10:   result = op2;
            2'b01:   result = op1;
            2'b11:   result = {op1[W-1] & op2[W-1], {(W-1){1'b0}}};
            default: result = {op3_sign, op3_exp, op3_frac};
        endcase
    end
endmodule

// File: rtl/fp_op_issue.sv
// Two-stage issue/collect pipeline driving a combinational FP unit over op_intf.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never depends on ready.
module fp_op_issue
    import fpu_pkg::*;
#(
    parameter  int EXP_WIDTH  = BF16_EXP_W,
    parameter  int FRAC_WIDTH = BF16_FRAC_W,
    parameter  int CNT_WIDTH  = 16,
    localparam int W          = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_op1,
    input  logic [W-1:0]         in_op2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_result,
    output logic [CNT_WIDTH-1:0] done_cnt,
    op_intf.drive_side           op_intf
);
    logic         s1_valid;
    logic [W-1:0] s1_op1;
    logic [W-1:0] s1_op2;
    logic         s2_adv;
    logic [W-1:0] sel_result;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    // The compute unit only ever sees registered operands, forced to zero when S1 is empty.
    assign op_intf.op1_sign = s1_valid & s1_op1[W-1];
    assign op_intf.op1_exp  = s1_valid ? s1_op1[W-2 -: EXP_WIDTH] : '0;
    assign op_intf.op1_frac = s1_valid ? s1_op1[FRAC_WIDTH-1:0] : '0;
    assign op_intf.op2_sign = s1_valid & s1_op2[W-1];
    assign op_intf.op2_exp  = s1_valid ? s1_op2[W-2 -: EXP_WIDTH] : '0;
    assign op_intf.op2_frac = s1_valid ? s1_op2[FRAC_WIDTH-1:0] : '0;

    fp_zero_bypass #(
        .EXP_WIDTH (EXP_WIDTH),
        .FRAC_WIDTH(FRAC_WIDTH)
    ) u_bypass (
        .op1     (s1_op1),
        .op2     (s1_op2),
        .op3_sign(op_intf.op3_sign),
        .op3_exp (op_intf.op3_exp),
        .op3_frac(op_intf.op3_frac),
        .result  (sel_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op1   <= '0;
            s1_op2   <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_op1   <= in_op1;
            s1_op2   <= in_op2;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= sel_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt <= done_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_fp_op_issue.sv
// Bench for fp_op_issue with fp_add behind a shared op_intf; an 8-bit counter keeps wrap reachable.
module tb_fp_op_issue;
    import fpu_pkg::*;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_op1 = '0;
    logic [15:0]   in_op2 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_result;
    logic [CW-1:0] done_cnt;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];

    op_intf #(.EXP_WIDTH(8), .FRAC_WIDTH(7)) op_if ();

    fp_add #(.EXP_WIDTH(8), .FRAC_WIDTH(7)) u_add (.op_if(op_if));

    fp_op_issue #(.EXP_WIDTH(8), .FRAC_WIDTH(7), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op1    (in_op1),
        .in_op2    (in_op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .done_cnt  (done_cnt),
        .op_intf   (op_if)
    );

    always #5 clk = ~clk;

    // Exact same-sign sum of two normals, then truncated to 8 significant bits.
    function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, emin, p;
        logic [47:0] v;
        logic [47:0] m;
        ea   = int'(a[14:7]);
        eb   = int'(b[14:7]);
        emin = (ea < eb) ? ea : eb;
        v    = (48'({1'b1, a[6:0]}) << (ea - emin)) + (48'({1'b1, b[6:0]}) << (eb - emin));
        p    = 0;
        for (int i = 0; i < 48; i++) if (v[i]) p = i;
        m = v >> (p - 7);
        return {a[15], 8'(emin + p - 7), m[6:0]};
    endfunction

    function automatic logic [15:0] rand_normal(input logic s);
        return {s, 8'($urandom_range(110, 140)), 7'($urandom_range(0, 127))};
    endfunction

    task automatic reset_dut();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sends one pair with out_ready held high; returns the result seen while out_valid is up.
    task automatic run_pair(input logic [15:0] a, input logic [15:0] b,
                            output logic [15:0] r, output bit to);
        int n;
        to = 1'b0;
        r  = '0;
        @(negedge clk);
        in_op1 = a; in_op2 = b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
        if (!in_ready) begin to = 1'b1; in_valid = 1'b0; return; end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); #1; n++; end
        if (!out_valid) to = 1'b1;
        else r = out_result;
    endtask

    task automatic test_reset();
        reset_dut();
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_result !== 16'h0000) begin failures++; $display("FAIL rst_out_result got=%h exp=0000", out_result); end
        checks++; if (done_cnt !== '0) begin failures++; $display("FAIL rst_done_cnt got=%0d exp=0", done_cnt); end
        checks++;
        if ({op_if.op1_sign, op_if.op1_exp, op_if.op1_frac, op_if.op2_sign, op_if.op2_exp, op_if.op2_frac} !== 32'h0) begin
            failures++; $display("FAIL rst_op_intf got=%h%h exp=00000000",
                {op_if.op1_sign, op_if.op1_exp, op_if.op1_frac}, {op_if.op2_sign, op_if.op2_exp, op_if.op2_frac});
        end
    endtask

    task automatic test_latency();
        reset_dut();
        @(negedge clk);
        in_op1 = 16'h3F80; in_op2 = 16'h3F80; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lat_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_early_valid got=%b exp=0", out_valid); end
        checks++;
        if ({op_if.op1_sign, op_if.op1_exp, op_if.op1_frac} !== 16'h3F80) begin
            failures++; $display("FAIL lat_op1_drive got=%h exp=3f80", {op_if.op1_sign, op_if.op1_exp, op_if.op1_frac});
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b exp=1", out_valid); end
        checks++; if (out_result !== 16'h4000) begin failures++; $display("FAIL lat_result got=%h exp=4000", out_result); end
        @(posedge clk); #1;
        checks++; if (done_cnt !== CW'(1)) begin failures++; $display("FAIL lat_done_cnt got=%0d exp=1", done_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_table();
        logic [15:0] ta[6] = '{16'h3FC0, 16'h3F80, 16'h0000, 16'h8000, 16'h0000, 16'h0001};
        logic [15:0] tb[6] = '{16'h3FC0, 16'h0000, 16'hC000, 16'h8000, 16'h8000, 16'h4000};
        logic [15:0] te[6] = '{16'h4040, 16'h3F80, 16'hC000, 16'h8000, 16'h0000, 16'h4000};
        logic [15:0] r;
        bit to;
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            run_pair(ta[i], tb[i], r, to);
            checks++;
            if (to || r !== te[i]) begin
                failures++; $display("FAIL table_%0d %h+%h got=%h exp=%h timeout=%0d", i, ta[i], tb[i], r, te[i], to);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] pa[3] = '{16'h3F80, 16'h4000, 16'h3FC0};
        logic [15:0] pe[3] = '{16'h4000, 16'h4080, 16'h4040};
        int idx = 0;
        int got = 0;
        reset_dut();
        for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 6);
            if (idx < 3) begin in_op1 = pa[idx]; in_op2 = pa[idx]; in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            if (cyc == 5) begin
                checks++; if (idx !== 2) begin failures++; $display("FAIL stall_captured got=%0d exp=2", idx); end
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
            end
            if (!out_ready && out_valid) begin
                checks++;
                if (out_result !== pe[0]) begin failures++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, out_result, pe[0]); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_result !== pe[got]) begin failures++; $display("FAIL stall_order_%0d got=%h exp=%h", got, out_result, pe[got]); end
                got++;
            end
            if (in_valid && in_ready) idx++;
        end
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if (got !== 3) begin failures++; $display("FAIL stall_count got=%0d exp=3", got); end
        checks++; if (done_cnt !== CW'(3)) begin failures++; $display("FAIL stall_done_cnt got=%0d exp=3", done_cnt); end
    endtask

    task automatic test_random();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit accepted = 1'b0;
        logic [15:0] e;
        logic [15:0] r;
        bit to;
        logic s;
        reset_dut();
        exp_q.delete();
        while (got < 200 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (accepted) begin in_valid = 1'b0; accepted = 1'b0; end
            if (!in_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
                s = 1'($urandom_range(0, 1));
                in_op1 = rand_normal(s); in_op2 = rand_normal(s); in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand_extra got=%h exp=none", out_result);
                end else begin
                    e = exp_q.pop_front();
                    if (out_result !== e) begin failures++; $display("FAIL rand_%0d got=%h exp=%h", got, out_result, e); end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_add(in_op1, in_op2));
                sent++;
                accepted = 1'b1;
            end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0; #1;
        checks++; if (got !== 200) begin failures++; $display("FAIL rand_timeout got=%0d exp=200", got); end
        checks++; if (done_cnt !== CW'(200)) begin failures++; $display("FAIL rand_done_cnt got=%0d exp=200", done_cnt); end
        for (int i = 0; i < 55; i++) run_pair(16'h3F80, 16'h3F80, r, to);
        @(negedge clk); #1;
        checks++; if (done_cnt !== CW'(255)) begin failures++; $display("FAIL wrap_max got=%0d exp=255", done_cnt); end
        run_pair(16'h3F80, 16'h3F80, r, to);
        @(negedge clk); #1;
        checks++; if (done_cnt !== CW'(0)) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        bit to;
        reset_dut();
        run_pair(16'h3F80, 16'h3F80, r, to);
        @(negedge clk);
        out_ready = 1'b0; in_op1 = 16'h3F80; in_op2 = 16'h3F80; in_valid = 1'b1;
        @(negedge clk);
        in_op1 = 16'h3FC0; in_op2 = 16'h3FC0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL mid_full got=%b%b exp=10", out_valid, in_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        checks++; if (done_cnt !== '0) begin failures++; $display("FAIL mid_done_cnt got=%0d exp=0", done_cnt); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_%0d got=%b exp=0", i, out_valid); end
        end
        run_pair(16'h4000, 16'h4000, r, to);
        checks++; if (to || r !== 16'h4080) begin failures++; $display("FAIL mid_next got=%h exp=4080 timeout=%0d", r, to); end
        @(negedge clk); #1;
        checks++; if (done_cnt !== CW'(1)) begin failures++; $display("FAIL mid_next_cnt got=%0d exp=1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_table();
        test_stall();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
